// File: rtl/sa_iport_arb_if.sv
// Handshake bundle between one input port's VC buffers, its port-stage arbiter
// and the main switch allocator.
interface sa_iport_arb_if #(
  parameter int V = 4,
  parameter int N = 5
);
  logic [V-1:0]   vc_req;
  logic [V*N-1:0] vc_outport;
  logic [N-1:0]   reqPort_to_main;
  logic           Portgranted_from_main;
  logic [N-1:0]   selOutPort_from_main;
  logic [V-1:0]   vc_grant;
  logic [N-1:0]   xbar_sel;
  logic           st_valid;
  logic           err_proto;

  modport master (
    output vc_req, vc_outport, Portgranted_from_main, selOutPort_from_main,
    input  reqPort_to_main, vc_grant, xbar_sel, st_valid, err_proto
  );

  modport slave (
    input  vc_req, vc_outport, Portgranted_from_main, selOutPort_from_main,
    output reqPort_to_main, vc_grant, xbar_sel, st_valid, err_proto
  );
endinterface

// File: rtl/sa_iport_arb.sv
// Input-port stage of the two-stage switch allocator: round-robin VC pick,
// port request to the main allocator, registered dequeue/crossbar pulses.
module sa_iport_arb #(
  parameter int V = 4,
  parameter int N = 5
) (
  input logic           clk,
  input logic           rstn,
  sa_iport_arb_if.slave bus
);
  localparam int          PW       = (V > 1) ? $clog2(V) : 1;
  localparam int unsigned VU       = V;
  localparam logic [PW-1:0] PTR_LAST = PW'(V - 1);

  logic [PW-1:0] r_ptr;
  logic [V-1:0]  r_vc_grant;
  logic [N-1:0]  r_xbar_sel;
  logic          r_st_valid;
  logic          r_err_proto;

  logic [V-1:0]  w_onehot;
  logic [V-1:0]  w_elig;
  logic [V-1:0]  w_grant_vec;
  logic [N-1:0]  w_req_port;
  logic [PW-1:0] w_winner;
  logic [PW-1:0] w_ptr_next;
  logic          w_found;
  logic          w_accept;
  logic          w_proto_err;
  int unsigned   w_ptr_u;
  int unsigned   w_best;
  int unsigned   w_dist;

  function automatic logic is_onehot(input logic [N-1:0] x);
    return (x != '0) && ((x & (x - N'(1))) == '0);
  endfunction

  assign w_ptr_u = 32'(r_ptr);

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < VU; i++) begin
      w_onehot[i] = is_onehot(bus.vc_outport[i*N +: N]);
    end
  end

  // A VC granted last cycle is still dequeuing its flit, so it sits out one round.
  assign w_elig = bus.vc_req & ~r_vc_grant & w_onehot;

  // Rotating priority expressed as circular distance from the pointer; the
  // eligible VC with the smallest distance wins. Keeps wrap correct for any V.
  always_comb begin
    w_best     = VU;
    w_dist     = 0;
    w_winner   = '0;
    w_req_port = '0;
    for (int unsigned i = 0; i < VU; i++) begin
      if (w_elig[i]) begin
        w_dist = (i >= w_ptr_u) ? (i - w_ptr_u) : (i + VU - w_ptr_u);
        if (w_dist < w_best) begin
          w_best     = w_dist;
          w_winner   = PW'(i);
          w_req_port = bus.vc_outport[i*N +: N];
        end
      end
    end
  end

  assign w_found = (w_best != VU);

  always_comb begin
    w_grant_vec           = '0;
    w_grant_vec[w_winner] = 1'b1;
  end

  assign w_ptr_next = (w_winner == PTR_LAST) ? '0 : (w_winner + PW'(1));

  assign w_accept = bus.Portgranted_from_main & w_found &
                    (bus.selOutPort_from_main == w_req_port);

  assign w_proto_err = (|(bus.vc_req & ~w_onehot)) |
                       (bus.Portgranted_from_main & ~w_accept);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr       <= '0;
      r_vc_grant  <= '0;
      r_xbar_sel  <= '0;
      r_st_valid  <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_err_proto <= r_err_proto | w_proto_err;
      if (w_accept) begin
        r_vc_grant <= w_grant_vec;
        r_xbar_sel <= bus.selOutPort_from_main;
        r_st_valid <= 1'b1;
        r_ptr      <= w_ptr_next;
      end else begin
        r_vc_grant <= '0;
        r_xbar_sel <= '0;
        r_st_valid <= 1'b0;
      end
    end
  end

  assign bus.reqPort_to_main = w_req_port;
  assign bus.vc_grant        = r_vc_grant;
  assign bus.xbar_sel        = r_xbar_sel;
  assign bus.st_valid        = r_st_valid;
  assign bus.err_proto       = r_err_proto;
endmodule

// File: tb/tb_sa_iport_arb.sv
// Bench for sa_iport_arb: directed scenarios plus randomized traffic against
// a queue-free round-robin reference model.
module tb_sa_iport_arb;
  localparam int V = 4;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sa_iport_arb_if #(.V(V), .N(N)) bus();
  sa_iport_arb #(.V(V), .N(N)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model state
  int           m_ptr;
  int           m_prev;
  logic         m_err;
  logic [N-1:0] m_req;
  int           m_win;
  logic         m_acc;
  logic [V-1:0] m_grant;
  logic [N-1:0] m_xbar;
  logic         m_st;

  function automatic logic [V*N-1:0] pack4(input logic [N-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_prev = -1; m_err = 1'b0;
    m_grant = '0; m_xbar = '0; m_st = 1'b0;
  endtask

  task automatic model_eval();
    m_win = -1;
    m_req = '0;
    for (int k = 0; k < V; k++) begin
      int i;
      logic [N-1:0] s;
      i = (m_ptr + k) % V;
      s = bus.vc_outport[i*N +: N];
      if (m_win < 0 && bus.vc_req[i] && i != m_prev && $countones(s) == 1) begin
        m_win = i;
        m_req = s;
      end
    end
    m_acc = bus.Portgranted_from_main && (m_win >= 0) && (bus.selOutPort_from_main == m_req);
  endtask

  task automatic model_step();
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < V; i++)
      if (bus.vc_req[i] && $countones(bus.vc_outport[i*N +: N]) != 1) bad = 1'b1;
    m_err = m_err | bad | (bus.Portgranted_from_main && !m_acc);
    if (m_acc) begin
      m_grant = '0;
      m_grant[m_win] = 1'b1;
      m_xbar = bus.selOutPort_from_main;
      m_st   = 1'b1;
      m_prev = m_win;
      m_ptr  = (m_win + 1) % V;
    end else begin
      m_grant = '0; m_xbar = '0; m_st = 1'b0; m_prev = -1;
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    bus.vc_req = '0; bus.vc_outport = '0;
    bus.Portgranted_from_main = 1'b0; bus.selOutPort_from_main = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.vc_req = 4'b1111;
    bus.vc_outport = pack4(5'b00001, 5'b00010, 5'b00100, 5'b01000);
    bus.Portgranted_from_main = 1'b0;
    bus.selOutPort_from_main = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.vc_grant !== 4'b0000) begin errors++; $display("FAIL reset_vc_grant got=%b exp=0000", bus.vc_grant); end
    checks++; if (bus.xbar_sel !== 5'b00000) begin errors++; $display("FAIL reset_xbar_sel got=%b exp=00000", bus.xbar_sel); end
    checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL reset_st_valid got=%b exp=0", bus.st_valid); end
    checks++; if (bus.err_proto !== 1'b0) begin errors++; $display("FAIL reset_err_proto got=%b exp=0", bus.err_proto); end
    rstn = 1'b1;
    #1;
    checks++; if (bus.reqPort_to_main !== 5'b00001) begin errors++; $display("FAIL reset_reqport got=%b exp=00001", bus.reqPort_to_main); end
    @(posedge clk); #1;
    checks++; if (bus.vc_grant !== 4'b0000) begin errors++; $display("FAIL idle_vc_grant got=%b exp=0000", bus.vc_grant); end
    checks++; if (bus.err_proto !== 1'b0) begin errors++; $display("FAIL idle_err_proto got=%b exp=0", bus.err_proto); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] ep;
    logic [V-1:0] eg;
    bus.Portgranted_from_main = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ep = '0; ep[k % V] = 1'b1;
      eg = '0; eg[k % V] = 1'b1;
      bus.selOutPort_from_main = ep;
      #1;
      checks++; if (bus.reqPort_to_main !== ep) begin errors++; $display("FAIL rr_reqport step=%0d got=%b exp=%b", k, bus.reqPort_to_main, ep); end
      @(posedge clk); #1;
      checks++; if (bus.vc_grant !== eg) begin errors++; $display("FAIL rr_vc_grant step=%0d got=%b exp=%b", k, bus.vc_grant, eg); end
      checks++; if (bus.xbar_sel !== ep) begin errors++; $display("FAIL rr_xbar_sel step=%0d got=%b exp=%b", k, bus.xbar_sel, ep); end
      checks++; if (bus.st_valid !== 1'b1) begin errors++; $display("FAIL rr_st_valid step=%0d got=%b exp=1", k, bus.st_valid); end
    end
    bus.Portgranted_from_main = 1'b0;
  endtask

  task automatic test_denied();
    apply_reset();
    bus.vc_req = 4'b0100;
    bus.vc_outport = pack4(5'b0, 5'b0, 5'b01000, 5'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bus.reqPort_to_main !== 5'b01000) begin errors++; $display("FAIL denied_reqport cyc=%0d got=%b exp=01000", k, bus.reqPort_to_main); end
      @(posedge clk); #1;
      checks++; if (bus.vc_grant !== 4'b0000 || bus.st_valid !== 1'b0) begin errors++; $display("FAIL denied_nogrant cyc=%0d got=%b/%b exp=0000/0", k, bus.vc_grant, bus.st_valid); end
    end
    bus.Portgranted_from_main = 1'b1;
    bus.selOutPort_from_main = 5'b01000;
    @(posedge clk); #1;
    checks++; if (bus.vc_grant !== 4'b0100) begin errors++; $display("FAIL denied_grant got=%b exp=0100", bus.vc_grant); end
    checks++; if (bus.xbar_sel !== 5'b01000) begin errors++; $display("FAIL denied_xbar got=%b exp=01000", bus.xbar_sel); end
    bus.Portgranted_from_main = 1'b0;
    bus.vc_req = 4'b1111;
    bus.vc_outport = pack4(5'b00001, 5'b00010, 5'b00100, 5'b10000);
    #1;
    checks++; if (bus.reqPort_to_main !== 5'b10000) begin errors++; $display("FAIL denied_ptr3 got=%b exp=10000", bus.reqPort_to_main); end
    checks++; if (bus.err_proto !== 1'b0) begin errors++; $display("FAIL denied_err got=%b exp=0", bus.err_proto); end
    @(posedge clk); #1;
  endtask

  task automatic test_mask();
    logic [N-1:0] ep;
    logic [V-1:0] eg;
    apply_reset();
    bus.vc_req = 4'b0010;
    bus.vc_outport = pack4(5'b0, 5'b00010, 5'b0, 5'b0);
    bus.Portgranted_from_main = 1'b1;
    bus.selOutPort_from_main = 5'b00010;
    for (int k = 0; k < 6; k++) begin
      ep = (k % 2 == 0) ? 5'b00010 : 5'b00000;
      eg = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      #1;
      checks++; if (bus.reqPort_to_main !== ep) begin errors++; $display("FAIL mask_reqport cyc=%0d got=%b exp=%b", k, bus.reqPort_to_main, ep); end
      @(posedge clk); #1;
      checks++; if (bus.vc_grant !== eg) begin errors++; $display("FAIL mask_vc_grant cyc=%0d got=%b exp=%b", k, bus.vc_grant, eg); end
    end
    checks++; if (bus.err_proto !== 1'b1) begin errors++; $display("FAIL mask_err_noreq got=%b exp=1", bus.err_proto); end
    bus.Portgranted_from_main = 1'b0;
  endtask

  task automatic test_protocol();
    apply_reset();
    bus.vc_req = 4'b0001;
    bus.vc_outport = pack4(5'b00100, 5'b0, 5'b0, 5'b0);
    bus.Portgranted_from_main = 1'b1;
    bus.selOutPort_from_main = 5'b00010;
    #1;
    checks++; if (bus.reqPort_to_main !== 5'b00100) begin errors++; $display("FAIL proto_reqport got=%b exp=00100", bus.reqPort_to_main); end
    @(posedge clk); #1;
    checks++; if (bus.vc_grant !== 4'b0000 || bus.st_valid !== 1'b0) begin errors++; $display("FAIL proto_nogrant got=%b/%b exp=0000/0", bus.vc_grant, bus.st_valid); end
    checks++; if (bus.err_proto !== 1'b1) begin errors++; $display("FAIL proto_err_mismatch got=%b exp=1", bus.err_proto); end
    bus.Portgranted_from_main = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.err_proto !== 1'b1) begin errors++; $display("FAIL proto_err_sticky got=%b exp=1", bus.err_proto); end
    // multi-hot VC0 must be skipped in favour of VC1
    apply_reset();
    bus.vc_req = 4'b0011;
    bus.vc_outport = pack4(5'b00110, 5'b00001, 5'b0, 5'b0);
    bus.Portgranted_from_main = 1'b1;
    bus.selOutPort_from_main = 5'b00001;
    #1;
    checks++; if (bus.reqPort_to_main !== 5'b00001) begin errors++; $display("FAIL proto_skip_reqport got=%b exp=00001", bus.reqPort_to_main); end
    @(posedge clk); #1;
    checks++; if (bus.vc_grant !== 4'b0010) begin errors++; $display("FAIL proto_skip_grant got=%b exp=0010", bus.vc_grant); end
    checks++; if (bus.err_proto !== 1'b1) begin errors++; $display("FAIL proto_err_multihot got=%b exp=1", bus.err_proto); end
    // zero port vector
    apply_reset();
    bus.vc_req = 4'b0001;
    bus.vc_outport = '0;
    #1;
    checks++; if (bus.reqPort_to_main !== 5'b00000) begin errors++; $display("FAIL proto_zero_reqport got=%b exp=00000", bus.reqPort_to_main); end
    @(posedge clk); #1;
    checks++; if (bus.err_proto !== 1'b1) begin errors++; $display("FAIL proto_err_zero got=%b exp=1", bus.err_proto); end
  endtask

  task automatic test_random();
    logic [V*N-1:0] op;
    logic [N-1:0]   s;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 64 == 63) apply_reset();
      bus.vc_req = V'($urandom);
      op = '0;
      for (int i = 0; i < V; i++) begin
        int r;
        r = $urandom_range(0, 59);
        if (r == 0) s = '0;
        else if (r == 1) s = 5'b00011 << $urandom_range(0, 3);
        else begin s = '0; s[$urandom_range(0, N-1)] = 1'b1; end
        op[i*N +: N] = s;
      end
      bus.vc_outport = op;
      bus.Portgranted_from_main = 1'b0;
      model_eval();
      if (m_req != '0) bus.Portgranted_from_main = ($urandom_range(0, 9) < 7);
      else bus.Portgranted_from_main = ($urandom_range(0, 49) == 0);
      bus.selOutPort_from_main = ($urandom_range(0, 19) == 0) ? N'($urandom) : m_req;
      model_eval();
      #1;
      checks++; if (bus.reqPort_to_main !== m_req) begin errors++; $display("FAIL rand_reqport cyc=%0d got=%b exp=%b", c, bus.reqPort_to_main, m_req); end
      @(posedge clk);
      model_step();
      #1;
      checks++; if (bus.vc_grant !== m_grant) begin errors++; $display("FAIL rand_vc_grant cyc=%0d got=%b exp=%b", c, bus.vc_grant, m_grant); end
      checks++; if (bus.xbar_sel !== m_xbar) begin errors++; $display("FAIL rand_xbar_sel cyc=%0d got=%b exp=%b", c, bus.xbar_sel, m_xbar); end
      checks++; if (bus.st_valid !== m_st) begin errors++; $display("FAIL rand_st_valid cyc=%0d got=%b exp=%b", c, bus.st_valid, m_st); end
      checks++; if (bus.err_proto !== m_err) begin errors++; $display("FAIL rand_err_proto cyc=%0d got=%b exp=%b", c, bus.err_proto, m_err); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_denied();
    test_mask();
    test_protocol();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
